// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffered feeder for uart_tx.
// Words pushed on a single-cycle interface are queued in a synchronous FIFO
// and handed to the transmitter one at a time. Each word gets a stretched
// wr strobe, then a full buffempty low/high handshake, so the slower
// uart_clk domain always captures it.
// Optional feature: define UART_TX_FEEDER_TIMEOUT_EN to add a busy timeout
// in WAIT_BUSY. A timeout re-strobes the word once, and a second timeout
// drops it. Without the macro, WAIT_BUSY waits indefinitely.
// rst asserts asynchronously. Its release is expected to be synchronous to
// clk, which is the job of the reset source.
module uart_tx_feeder #(
    parameter int ADDR_W       = 4,
    parameter int WR_PULSE     = 8
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    ,
    parameter int BUSY_TIMEOUT = 1023
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [8:0]        push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [8:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_buffempty,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int PW    = $clog2(WR_PULSE + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_BUSY,
        S_WAIT_EMPTY
    } state_t;

    state_t              r_state;
    logic [8:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic                r_overflow;
    logic                r_be_meta;
    logic                r_be_s;
    logic [8:0]          r_tx_data;
    logic                r_tx_wr;
    logic                r_busy;
    logic [PW-1:0]       r_pulse_cnt;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    logic [TW-1:0]       r_to_cnt;
    logic                r_retry;
`endif

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == (ADDR_W+1)'(DEPTH));
    // A pop needs a word already stored, so a push to an empty FIFO never bypasses.
    assign w_pop     = (r_state == S_IDLE) && !w_empty && r_be_s;
    // When the FIFO is full, a push is still taken if a pop frees the slot in the same cycle.
    assign w_push_ok = push && (!w_full || w_pop);

    // Two-flop synchronizer for buffempty from the uart_clk domain. It idles high (empty).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_be_meta <= 1'b1;
            r_be_s    <= 1'b1;
        end else begin
            r_be_meta <= tx_buffempty;
            r_be_s    <= r_be_meta;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse for dropped pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= push && !w_push_ok;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // FIFO storage. A simultaneous push and pop on a full FIFO hits the same slot,
    // and the FSM reads the old word there.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= push_data;
    end

    // Transfer sequencer: pop, hold wr for WR_PULSE cycles, then wait for buffempty to go low and back high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tx_data   <= '0;
            r_tx_wr     <= 1'b0;
            r_busy      <= 1'b0;
            r_pulse_cnt <= '0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_retry     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data   <= r_mem[r_rd_ptr];
                        r_tx_wr     <= 1'b1;
                        r_pulse_cnt <= PW'(WR_PULSE - 1);
                        r_busy      <= 1'b1;
                        r_state     <= S_STROBE;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                        r_retry     <= 1'b0;
`endif
                    end
                end
                S_STROBE: begin
                    if (r_pulse_cnt == '0) begin
                        r_tx_wr <= 1'b0;
                        r_state <= S_WAIT_BUSY;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt - PW'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    if (!r_be_s) begin
                        r_state <= S_WAIT_EMPTY;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
                    end else if (r_to_cnt == TW'(BUSY_TIMEOUT - 1)) begin
                        // The strobe was missed: re-send the same word once, then give up.
                        if (!r_retry) begin
                            r_retry     <= 1'b1;
                            r_tx_wr     <= 1'b1;
                            r_pulse_cnt <= PW'(WR_PULSE - 1);
                            r_state     <= S_STROBE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
`endif
                    end
                end
                S_WAIT_EMPTY: begin
                    if (r_be_s) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign tx_wr    = r_tx_wr;
    assign busy     = r_busy;

endmodule
